// File: rtl/sram_port_ctrl.sv
// Single-port SRAM front-end: clears the array after reset, then serves reads and
// writes from a valid/ready request channel and returns read data on a response channel.
module sram_port_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              oob_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_oob_err;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                w_rsp_valid_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic                w_oob_err_nxt;
    logic                w_accept;
    logic                w_oob;

    // The extra top bit lets DEPTH == 2**ADDR_W compare correctly (nothing is out of range).
    assign w_oob    = ({1'b0, req_addr} >= DEPTH_EXT);
    assign w_accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_oob_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_oob_err   <= w_oob_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_oob_err_nxt   = r_oob_err | (w_accept & w_oob);

        req_ready = (r_state == ST_IDLE) | ((r_state == ST_RSP) & rsp_ready);
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_d     = req_wdata;

        case (r_state)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = r_cnt;
                mem_d     = '0;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IDLE, ST_RSP: begin
                if ((r_state == ST_RSP) && rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
                if (w_accept) begin
                    if (req_we) begin
                        mem_we = ~w_oob;
                    end else begin
                        // A read accepted alongside a consumed response reloads the slot.
                        w_state_nxt     = ST_RSP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = w_oob ? '0 : mem_q;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign oob_err   = r_oob_err;
    assign init_done = (r_state != ST_INIT);

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl: a DEPTH=64 instance for the main traffic and a
// DEPTH=48 instance for out-of-range handling, each backed by a simple memory model.
module tb_sram_port_ctrl;

    logic       clk;
    logic       rst_n;
    logic       scrub;
    logic       req_we;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;
    logic       v64, v48;

    logic       rdy64, rv64, idone64, oob64, we64;
    logic [7:0] rd64, d64, q64;
    logic [5:0] a64;
    logic       rdy48, rv48, idone48, oob48, we48;
    logic [7:0] rd48, d48, q48;
    logic [5:0] a48;

    logic [7:0] mem64 [64];
    logic [7:0] mem48 [64];

    int n_pass = 0;
    int n_tot  = 0;

    sram_port_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v64), .req_ready(rdy64), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv64), .rsp_ready(rsp_ready), .rsp_rdata(rd64),
        .init_done(idone64), .oob_err(oob64),
        .mem_we(we64), .mem_addr(a64), .mem_d(d64), .mem_q(q64)
    );

    sram_port_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(48)) u_dut48 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v48), .req_ready(rdy48), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv48), .rsp_ready(rsp_ready), .rsp_rdata(rd48),
        .init_done(idone48), .oob_err(oob48),
        .mem_we(we48), .mem_addr(a48), .mem_d(d48), .mem_q(q48)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models start filled with 0xEE so the clear sequence is observable.
    always @(posedge clk) begin
        if (scrub) begin
            for (int i = 0; i < 64; i++) begin
                mem64[i] <= 8'hEE;
                mem48[i] <= 8'hEE;
            end
        end else begin
            if (we64) mem64[a64] <= d64;
            if (we48) mem48[a48] <= d48;
        end
    end
    assign q64 = mem64[a64];
    assign q48 = mem48[a48];

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_init(output int e64, output int e48, output int early);
        e64 = 0; e48 = 0; early = 0;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            if (rdy64 && !idone64) early++;
            if (idone64 && e64 == 0) e64 = k;
            if (idone48 && e48 == 0) e48 = k;
            if (e64 != 0 && e48 != 0) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e64, e48, early;

        tbl[0]  = '{1'b1, 6'd5,  8'hA5, 8'h00};
        tbl[1]  = '{1'b0, 6'd5,  8'h00, 8'hA5};
        tbl[2]  = '{1'b1, 6'd0,  8'h11, 8'h00};
        tbl[3]  = '{1'b1, 6'd1,  8'h22, 8'h00};
        tbl[4]  = '{1'b1, 6'd2,  8'h33, 8'h00};
        tbl[5]  = '{1'b0, 6'd0,  8'h00, 8'h11};
        tbl[6]  = '{1'b0, 6'd1,  8'h00, 8'h22};
        tbl[7]  = '{1'b0, 6'd2,  8'h00, 8'h33};
        tbl[8]  = '{1'b0, 6'd7,  8'h00, 8'h00};
        tbl[9]  = '{1'b1, 6'd63, 8'h5A, 8'h00};
        tbl[10] = '{1'b0, 6'd63, 8'h00, 8'h5A};
        tbl[11] = '{1'b0, 6'd5,  8'h00, 8'hA5};

        rst_n = 1'b0; scrub = 1'b1; v64 = 1'b0; v48 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        scrub = 1'b0;
        req_addr = 6'd17; req_wdata = 8'h99;
        #1;
        chk("rst_req_ready", rdy64, 0);
        chk("rst_rsp_valid", rv64, 0);
        chk("rst_rsp_rdata", rd64, 0);
        chk("rst_init_done", idone64, 0);
        chk("rst_oob_err", oob64, 0);
        chk("rst_mem_we", we64, 1);
        chk("rst_mem_addr", a64, 0);
        chk("rst_mem_d", d64, 0);

        #1 rst_n = 1'b1;
        wait_init(e64, e48, early);
        chk("init_edges_64", e64, 64);
        chk("init_edges_48", e48, 48);
        chk("ready_before_init", early, 0);
        chk("ready_after_init", rdy64, 1);
        chk("oob_after_init", oob64, 0);

        // Sweep every word with back-to-back reads.
        v64 = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
        for (int a = 0; a < 64; a++) begin
            req_addr = 6'(a);
            @(posedge clk); #1;
            chk("clear_sweep_valid", rv64, 1);
            chk("clear_sweep_data", rd64, 0);
        end

        for (int i = 0; i < 12; i++) begin
            req_we = tbl[i].we; req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
            #1;
            chk("vec_req_ready", rdy64, 1);
            @(posedge clk); #1;
            chk("vec_rsp_valid", rv64, {31'd0, ~tbl[i].we});
            if (!tbl[i].we) chk("vec_rsp_rdata", rd64, tbl[i].exp);
        end

        // Back-pressure: held response blocks a pending write.
        req_we = 1'b0; req_addr = 6'd1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_we = 1'b1; req_addr = 6'd3; req_wdata = 8'h77;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("bp_rsp_valid", rv64, 1);
            chk("bp_rsp_rdata", rd64, 8'h22);
            chk("bp_req_ready", rdy64, 0);
            chk("bp_mem_we", we64, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", rdy64, 1);
        chk("bp_release_we", we64, 1);
        @(posedge clk); #1;
        chk("bp_after_write_valid", rv64, 0);
        req_we = 1'b0; req_addr = 6'd3;
        @(posedge clk); #1;
        chk("bp_readback", rd64, 8'h77);
        v64 = 1'b0;
        @(posedge clk); #1;
        chk("bp_idle_valid", rv64, 0);

        // Out-of-range on the DEPTH=48 instance.
        chk("oob_clear_before", oob48, 0);
        v48 = 1'b1; req_we = 1'b1; req_addr = 6'd50; req_wdata = 8'hFF;
        #1;
        chk("oob_wr_ready", rdy48, 1);
        chk("oob_wr_mem_we", we48, 0);
        @(posedge clk); #1;
        chk("oob_set_after_wr", oob48, 1);
        chk("oob_wr_dropped", mem48[50], 8'hEE);
        chk("oob_wr_no_rsp", rv48, 0);
        req_we = 1'b0;
        @(posedge clk); #1;
        chk("oob_rd_valid", rv48, 1);
        chk("oob_rd_data", rd48, 0);
        chk("oob_sticky_rd", oob48, 1);
        req_we = 1'b1; req_addr = 6'd47; req_wdata = 8'h42;
        @(posedge clk); #1;
        req_we = 1'b0;
        @(posedge clk); #1;
        chk("inrange_48_data", rd48, 8'h42);
        chk("oob_sticky_end", oob48, 1);
        chk("oob_not_on_64", oob64, 0);
        v48 = 1'b0;

        // Reset arriving while a response is held.
        v64 = 1'b1; req_we = 1'b1; req_addr = 6'd9; req_wdata = 8'h3C; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        v64 = 1'b0;
        chk("mid_pending_valid", rv64, 1);
        chk("mid_pending_data", rd64, 8'h3C);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", rv64, 0);
        chk("mid_rst_rdata", rd64, 0);
        chk("mid_rst_init_done", idone64, 0);
        chk("mid_rst_ready", rdy64, 0);
        chk("mid_rst_oob48", oob48, 0);
        chk("mid_rst_mem_addr", a64, 0);
        #3 rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_init(e64, e48, early);
        chk("mid_init_edges", e64, 64);
        chk("mid_ready_before_init", early, 0);
        v64 = 1'b1; req_we = 1'b0; req_addr = 6'd9;
        @(posedge clk); #1;
        chk("mid_read9_valid", rv64, 1);
        chk("mid_read9_data", rd64, 0);
        v64 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
